// File: rtl/mem_bus_pkg.sv
// Shared definitions for the 128-bit on-chip memory bus: widths, FSM states
// and write-response codes.
package mem_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [31:0] WRESP_OKAY = 32'h0;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WREQ,
    WRESP,
    RESP
  } state_t;

endpackage

// File: rtl/axi_lite_wr_track.sv
// Write-address / write-data handshake tracker: drives both valids and keeps a
// done flag per channel so the two handshakes may complete in any order.
module axi_lite_wr_track (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic awReady,
  input  logic wReady,
  output logic awValid,
  output logic wValid,
  output logic done
);

  logic awDone;
  logic wDone;
  logic awHs;
  logic wHs;

  assign awHs = awValid & awReady;
  assign wHs  = wValid & wReady;
  // Includes this cycle's handshakes so the FSM can leave on the completing edge.
  assign done = (awDone | awHs) & (wDone | wHs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awValid <= 1'b0;
      wValid  <= 1'b0;
      awDone  <= 1'b0;
      wDone   <= 1'b0;
    end else begin
      if (start) begin
        awValid <= 1'b1;
        wValid  <= 1'b1;
      end else begin
        if (awHs) awValid <= 1'b0;
        if (wHs)  wValid  <= 1'b0;
      end
      if (done) begin
        awDone <= 1'b0;
        wDone  <= 1'b0;
      end else begin
        if (awHs) awDone <= 1'b1;
        if (wHs)  wDone  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite initiator bridging a request/response port to the SRAM bus.
// Define AXI_MASTER_ALIGN_CHECK_EN to reject non-16-byte-aligned requests without a bus access.
module axi_lite_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = mem_bus_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_bus_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   readAddr_addr,
  output logic                readAddr_valid,
  input  logic                readAddr_ready,
  input  logic [DATA_W-1:0]   readData_data,
  input  logic                readData_valid,
  output logic                readData_ready,
  output logic [ADDR_W-1:0]   writeAddr_addr,
  output logic                writeAddr_valid,
  input  logic                writeAddr_ready,
  output logic [DATA_W-1:0]   writeData_data,
  output logic [DATA_W/8-1:0] writeData_strb,
  output logic                writeData_valid,
  input  logic                writeData_ready,
  input  logic [31:0]         writeResp_msg,
  input  logic                writeResp_valid,
  output logic                writeResp_ready
);

  state_t state;
  logic   misaligned;
  logic   wrStart;
  logic   wrDone;

`ifdef AXI_MASTER_ALIGN_CHECK_EN
  assign misaligned = |req_addr[3:0];
`else
  assign misaligned = 1'b0;
`endif

  assign req_ready       = (state == IDLE);
  assign readData_ready  = (state == RDATA);
  assign writeResp_ready = (state == WRESP);
  assign wrStart         = req_ready & req_valid & req_write & ~misaligned;

  axi_lite_wr_track u_wrTrack (
    .clk     (clk),
    .rst     (rst),
    .start   (wrStart),
    .awReady (writeAddr_ready),
    .wReady  (writeData_ready),
    .awValid (writeAddr_valid),
    .wValid  (writeData_valid),
    .done    (wrDone)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      readAddr_addr  <= '0;
      readAddr_valid <= 1'b0;
      writeAddr_addr <= '0;
      writeData_data <= '0;
      writeData_strb <= '0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (misaligned) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= RESP;
            end else if (req_write) begin
              writeAddr_addr <= req_addr;
              writeData_data <= req_wdata;
              writeData_strb <= req_strb;
              state          <= WREQ;
            end else begin
              readAddr_addr  <= req_addr;
              readAddr_valid <= 1'b1;
              state          <= RADDR;
            end
          end
        end
        RADDR: begin
          if (readAddr_ready) begin
            readAddr_valid <= 1'b0;
            state          <= RDATA;
          end
        end
        RDATA: begin
          if (readData_valid) begin
            rsp_rdata <= readData_data;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        WREQ: begin
          if (wrDone) state <= WRESP;
        end
        WRESP: begin
          if (writeResp_valid) begin
            rsp_err   <= (writeResp_msg != WRESP_OKAY);
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- AXI-Lite-4 initiator that turns a simple single-beat request/response port into transactions on the 128-bit memory bus.
- Drives the read-address, read-data, write-address, write-data and write-response channels of the on-chip SRAM slave.
- Placed between the core/cache-refill logic and the SRAM, so every 16-byte line access goes through one initiator.
- One transaction outstanding at a time.

Parameters:
- ADDR_W, 32, width of the readAddr_addr and writeAddr_addr ports and of req_addr; fixed at 32 by the bus.
- DATA_W, 128, bus data width; strobe width is DATA_W/8 (16).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  128  write data
- req_strb  in  16  byte enables for the write
- rsp_valid  out  1  response valid; held until rsp_ready
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  128  read data; 0 for writes
- rsp_err  out  1  error flag: writeResp_msg nonzero, or misaligned access (see Optional Feature)
- readAddr_addr  out  32  read address
- readAddr_valid  out  1  read address valid
- readAddr_ready  in  1  slave accepts the read address
- readData_data  in  128  read data from the slave
- readData_valid  in  1  read data valid
- readData_ready  out  1  initiator accepts read data
- writeAddr_addr  out  32  write address
- writeAddr_valid  out  1  write address valid
- writeAddr_ready  in  1  slave accepts the write address
- writeData_data  out  128  write data
- writeData_strb  out  16  write byte enables
- writeData_valid  out  1  write data valid
- writeData_ready  in  1  slave accepts the write data
- writeResp_msg  in  32  write response word
- writeResp_valid  in  1  write response valid
- writeResp_ready  out  1  initiator accepts the write response

Behaviour:
- States: IDLE, RADDR, RDATA, WREQ, WRESP, RESP. Reset → IDLE.
- Reset values: all valid/ready outputs and rsp_valid 0; rsp_rdata, rsp_err, both addr outputs, writeData_data and writeData_strb 0. Exception: req_ready reads 1 during reset because it is decoded from state.
- req_ready = (state==IDLE). Accepting a request registers addr, wdata, strb and write.
- IDLE→RADDR when a read is accepted; readAddr_valid=1 from the next cycle.
- RADDR: hold readAddr_valid and the address stable until readAddr_ready, then →RDATA.
- RDATA: readData_ready=1 (decoded from state). On readData_valid, capture readData_data into rsp_rdata, set rsp_err=0, →RESP.
- IDLE→WREQ when a write is accepted; writeAddr_valid and writeData_valid=1 together from the next cycle.
- WREQ: each valid drops in the cycle after its own handshake; aw_done and w_done flags are kept. Both handshakes in the same cycle is legal.
- WREQ→WRESP once both flags are set, whether set in the same or different cycles. Flags clear on leaving WREQ.
- WRESP: writeResp_ready=1. On writeResp_valid, set rsp_err = |writeResp_msg, set rsp_rdata=0, →RESP.
- RESP: rsp_valid=1, held with data stable until rsp_ready, then →IDLE. No new request is taken in RESP.
- Valid is never deasserted before its handshake, and payload does not change while valid is high.
- Minimum latency against a zero-wait slave:
  - read: accept→rsp_valid 3 cycles
  - write: 3 cycles plus the slave's response delay
- Slave signals arriving in a state that does not consume them (e.g. readData_valid in IDLE) are ignored.
- Reset mid-transaction aborts immediately to IDLE with all outputs at reset values. The bus is not drained; the slave is reset by the same rst.

Optional Feature:
- Macro AXI_MASTER_ALIGN_CHECK_EN.
- Defined: a request with req_addr[3:0]≠0 is accepted but issues no bus transaction. It goes IDLE→RESP directly, with rsp_err=1 and rsp_rdata=0.
- Undefined: the address is passed through unchecked; the SRAM handles unaligned byte addressing.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state encodings
  - ADDR_W and DATA_W, STRB_W
  - the WRESP_OKAY=32'h0 constant
- The write-side aw/w handshake tracker splits naturally into the sub-module axi_lite_wr_track, which holds the two done flags and the valid drivers.
- Everything else stays in one FSM.

Test Plan:
- Read, zero-wait slave: req addr 32'h0000_0040 → readAddr_addr=0x40; rsp_valid 3 cycles after accept, rsp_rdata equals slave data, rsp_err=0.
- Write, AW ready 2 cycles before W ready: data 128'hDEADBEEF…, strb 16'h00FF → each valid drops only after its own handshake; writeResp_ready asserted once both are done; rsp_err=0 on msg 0.
- Write response with writeResp_msg=32'h2 → rsp_err=1.
- Backpressure: rsp_ready held low 5 cycles → rsp_valid and rsp_rdata stable; req_ready=0 throughout; new request accepted the cycle after rsp_ready.
- rst pulsed while in RDATA → all valids 0 asynchronously, state IDLE; a following read completes normally.
- With AXI_MASTER_ALIGN_CHECK_EN: addr 32'h0000_0044 → no readAddr_valid pulse, rsp_err=1, rsp_valid on the cycle after accept.
